// File: rtl/id_ex_pipe_reg.sv
// Elastic ID->EX pipeline register: main entry plus a one-deep skid entry, flush-to-bubble, sync reset.
// Optional stall statistics counter enabled by defining ID_EX_STATS_EN.
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int CTRL_W  = 10,
  parameter int RADDR_W = 5
`ifdef ID_EX_STATS_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic               in_result_src,
  input  logic [XLEN-1:0]    in_rd1,
  input  logic [XLEN-1:0]    in_rd2,
  input  logic [XLEN-1:0]    in_imm,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [RADDR_W-1:0] in_radd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic               out_result_src,
  output logic [XLEN-1:0]    out_rd1,
  output logic [XLEN-1:0]    out_rd2,
  output logic [XLEN-1:0]    out_imm,
  output logic [XLEN-1:0]    out_pc,
  output logic [RADDR_W-1:0] out_radd
`ifdef ID_EX_STATS_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt
`endif
);

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic               result_src;
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
    logic [RADDR_W-1:0] radd;
  } payload_t;

  payload_t in_pay;
  payload_t main_q, main_d;
  payload_t skid_q;
  logic     main_valid_q, main_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     skid_load;

  assign in_pay = '{ctrl: in_ctrl, result_src: in_result_src, rd1: in_rd1, rd2: in_rd2,
                    imm: in_imm, pc: in_pc, radd: in_radd};

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready = ~skid_valid_q;

  always_comb begin
    // NOTE: every target gets a default before any branch, otherwise a missed path infers a latch.
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    skid_load    = 1'b0;

    if (flush) begin
      main_valid_d      = 1'b0;
      skid_valid_d      = 1'b0;
      main_d.ctrl       = '0;
      main_d.result_src = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_valid) begin
        main_d       = in_pay;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d      = 1'b0;
        main_d.ctrl       = '0;
        main_d.result_src = 1'b0;
      end
    end else if (in_valid && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_load    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // NOTE: skid payload has no reset; it is only ever read while skid_valid_q is set, which implies a prior capture.
  always_ff @(posedge clk) begin
    if (skid_load && !rst) begin
      skid_q <= in_pay;
    end
  end

  assign out_valid      = main_valid_q;
  assign out_ctrl       = main_q.ctrl;
  assign out_result_src = main_q.result_src;
  assign out_rd1        = main_q.rd1;
  assign out_rd2        = main_q.rd2;
  assign out_imm        = main_q.imm;
  assign out_pc         = main_q.pc;
  assign out_radd       = main_q.radd;

`ifdef ID_EX_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Saturating count of back-pressured cycles; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (main_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: vector table for cycle-exact state plus a FIFO scoreboard on every handshake.
module tb_id_ex_pipe_reg;

  localparam int XLEN    = 32;
  localparam int CTRL_W  = 10;
  localparam int RADDR_W = 5;
`ifdef ID_EX_STATS_EN
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic               rs;
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    pc;
    logic [RADDR_W-1:0] radd;
  } pay_t;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] pc;
    logic        exp_ov;
    logic        exp_ir;
    logic [31:0] exp_pc;
  } vec_t;

  logic               clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0]  in_ctrl, out_ctrl;
  logic               in_result_src, out_result_src;
  logic [XLEN-1:0]    in_rd1, in_rd2, in_imm, in_pc;
  logic [XLEN-1:0]    out_rd1, out_rd2, out_imm, out_pc;
  logic [RADDR_W-1:0] in_radd, out_radd;
`ifdef ID_EX_STATS_EN
  logic [CNT_W-1:0]   stall_cnt;
  int                 exp_stall = 0;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  pay_t sb_q[$];
  pay_t out_pay;
  vec_t vecs[15];

  id_ex_pipe_reg #(
    .XLEN(XLEN), .CTRL_W(CTRL_W), .RADDR_W(RADDR_W)
`ifdef ID_EX_STATS_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_result_src(in_result_src),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm), .in_pc(in_pc), .in_radd(in_radd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_result_src(out_result_src),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm), .out_pc(out_pc), .out_radd(out_radd)
`ifdef ID_EX_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign out_pay = {out_ctrl, out_result_src, out_rd1, out_rd2, out_imm, out_pc, out_radd};

  // Every payload field is a distinct function of the PC, so a mixed-up beat cannot alias.
  function automatic pay_t pay_of(input logic [31:0] pc);
    pay_t p;
    p.ctrl = {pc[9:2], 2'b11};
    p.rs   = 1'b1;
    p.rd1  = pc ^ 32'hA5A5_5A5A;
    p.rd2  = ~pc;
    p.imm  = pc + 32'd1;
    p.pc   = pc;
    p.radd = pc[6:2] ^ 5'd3;
    return p;
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic [31:0] pc);
    pay_t p;
    p             = pay_of(pc);
    in_valid      = iv;
    out_ready     = ordy;
    flush         = fl;
    in_ctrl       = p.ctrl;
    in_result_src = p.rs;
    in_rd1        = p.rd1;
    in_rd2        = p.rd2;
    in_imm        = p.imm;
    in_pc         = p.pc;
    in_radd       = p.radd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: mid-cycle sample predicts what the coming edge does.
  always @(negedge clk) begin
`ifdef ID_EX_STATS_EN
    if (rst) exp_stall = 0;
    else if (out_valid && !out_ready && exp_stall != CNT_MAX) exp_stall++;
`endif
    if (mon_en) begin
      if (!out_valid) begin
        check("bubble_ctrl", out_ctrl, 0);
        check("bubble_result_src", out_result_src, 0);
      end
      if (rst || flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("spurious_beat", out_pc, 32'hDEAD_BEEF);
          end else begin
            check("sb_payload", out_pay, sb_q.pop_front());
          end
        end
        if (in_valid && in_ready) sb_q.push_back(pay_of(in_pc));
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_payload", out_pay, 0);
    mon_en = 1'b1;
    rst    = 1'b0;

    //          iv    ordy  fl    pc            ov    ir    out_pc
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 1'b1, 32'h100};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h000, 1'b1, 1'b1, 32'h000};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h004, 1'b1, 1'b1, 32'h004};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h008, 1'b1, 1'b1, 32'h008};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 32'h008};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'h010, 1'b1, 1'b1, 32'h010};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'h014, 1'b1, 1'b0, 32'h010};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h098, 1'b1, 1'b0, 32'h010};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b1, 1'b1, 32'h014};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 32'h014};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h020, 1'b1, 1'b1, 32'h020};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h024, 1'b1, 1'b0, 32'h020};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 32'h028, 1'b0, 1'b1, 32'h020};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 32'h000, 1'b0, 1'b1, 32'h020};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 32'h030, 1'b1, 1'b1, 32'h030};

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].pc);
      tick();
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ir);
      check($sformatf("vec%0d_out_pc", i), out_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_out_ctrl", i), out_ctrl,
            vecs[i].exp_ov ? pay_of(vecs[i].exp_pc).ctrl : '0);
    end
    check("vec0_out_radd_seen", pay_of(32'h100).radd, 3);

    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();

    // Reset while both entries are occupied and another beat is offered.
    drive(1'b1, 1'b0, 1'b0, 32'h040);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h044);
    tick();
    check("bp_in_ready_low", in_ready, 0);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h048);
    tick();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_payload", out_pay, 0);
`ifdef ID_EX_STATS_EN
    check("midrst_stall_cnt", stall_cnt, 0);
`endif
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    check("postrst_no_ghost", out_valid, 0);

`ifdef ID_EX_STATS_EN
    drive(1'b1, 1'b0, 1'b0, 32'h050);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (20) tick();
    check("stall_sat_model", stall_cnt, exp_stall);
    check("stall_sat_value", stall_cnt, (20 > CNT_MAX) ? CNT_MAX : 20);
    drive(1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    check("stall_after_flush", stall_cnt, exp_stall);
    check("flush_out_valid", out_valid, 0);
`endif

    drive(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) tick();
    check("sb_drained", sb_q.size(), 0);
    check("idle_out_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
